// File: rtl/mdu_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
package mdu_pkg;

  localparam int WIDTH = 32;
  localparam int ITER  = WIDTH;
  localparam logic [WIDTH-1:0] DIV0_QUOT = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'b000,
    MDU_MULTU = 3'b001,
    MDU_DIV   = 3'b010,
    MDU_DIVU  = 3'b011,
    MDU_MTHI  = 3'b100,
    MDU_MTLO  = 3'b101
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } mdu_state_e;

  // Per-op control captured at start; the result signs are fixed up in FIX.
  typedef struct packed {
    logic is_div;
    logic neg_q;
    logic neg_r;
    logic div_zero;
  } mdu_ctl_t;

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate; used both for abs-in and sign-fix-out.
module mdu_sign_fix #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] val,
  output logic [W-1:0] res
);

  assign res = neg ? (~val + W'(1)) : val;

endmodule

// File: rtl/mul_div_unit.sv
// Radix-2 iterative MULT/MULTU/DIV/DIVU unit holding HI/LO, one bit per cycle
// on a shared 2*WIDTH accumulator and a single adder/subtractor.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = mdu_pkg::WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  mdu_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  mdu_ctl_t           ctl_q, ctl_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d, dz_q, dz_d;

  logic               signed_op, is_div_op;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  assign signed_op = (op == MDU_MULT) || (op == MDU_DIV);
  assign is_div_op = (op == MDU_DIV) || (op == MDU_DIVU);

  mdu_sign_fix #(.W(WIDTH)) u_abs_a (.neg(signed_op & a[WIDTH-1]), .val(a), .res(abs_a));
  mdu_sign_fix #(.W(WIDTH)) u_abs_b (.neg(signed_op & b[WIDTH-1]), .val(b), .res(abs_b));

  mdu_sign_fix #(.W(2*WIDTH)) u_fix_prod (.neg(ctl_q.neg_q), .val(acc_q), .res(prod_fix));
  mdu_sign_fix #(.W(WIDTH)) u_fix_quot (.neg(ctl_q.neg_q), .val(acc_q[WIDTH-1:0]), .res(quot_fix));
  mdu_sign_fix #(.W(WIDTH)) u_fix_rem (.neg(ctl_q.neg_r), .val(acc_q[2*WIDTH-1:WIDTH]), .res(rem_fix));

  // Shared adder: mul adds the multiplicand into the upper half when the
  // current multiplier bit is set; div subtracts the divisor from the
  // left-shifted partial remainder (W+2 bits so the borrow is the sign bit).
  logic [WIDTH:0]     rem;
  logic [WIDTH+1:0]   add_x, add_y, sum;
  logic               ge;
  logic [2*WIDTH-1:0] acc_step;

  always_comb begin
    rem = acc_q[2*WIDTH-1:WIDTH-1];
    if (ctl_q.is_div) begin
      add_x = {1'b0, rem};
      add_y = ~{2'b00, mcand_q};
    end else begin
      add_x = {2'b00, acc_q[2*WIDTH-1:WIDTH]};
      add_y = {2'b00, (acc_q[0] ? mcand_q : '0)};
    end
    sum = add_x + add_y + (WIDTH+2)'(ctl_q.is_div);
    ge  = ~sum[WIDTH+1];
    if (ctl_q.is_div)
      acc_step = {(ge ? sum[WIDTH-1:0] : rem[WIDTH-1:0]), acc_q[WIDTH-2:0], ge};
    else
      acc_step = {sum[WIDTH:0], acc_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    ctl_d   = ctl_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dz_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start && !flush) begin
          if (op == MDU_MTHI) begin
            hi_d = a;
          end else if (op == MDU_MTLO) begin
            lo_d = a;
          end else if (!op[2]) begin
            // Divide: dividend shifts out of the low half, divisor stays put.
            // Multiply: multiplier sits in the low half, multiplicand stays put.
            acc_d          = {{WIDTH{1'b0}}, (is_div_op ? abs_a : abs_b)};
            mcand_d        = is_div_op ? abs_b : abs_a;
            ctl_d.is_div   = is_div_op;
            ctl_d.neg_q    = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
            ctl_d.neg_r    = signed_op & a[WIDTH-1];
            ctl_d.div_zero = is_div_op & (b == '0);
            cnt_d          = '0;
            state_d        = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        if (flush) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          acc_d = acc_step;
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = ST_FIX;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        if (!flush) begin
          done_d = 1'b1;
          dz_d   = ctl_q.div_zero;
          if (ctl_q.is_div) begin
            hi_d = rem_fix;
            lo_d = ctl_q.div_zero ? WIDTH'(DIV0_QUOT) : quot_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      ctl_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      ctl_q   <= ctl_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: stimulus pushes expected HI/LO/div_zero,
// a negedge monitor pops and compares on every done pulse.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b110;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        flush = 1'b0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  mul_div_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .div_zero(div_zero),
    .hi(hi), .lo(lo)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 hi=%h lo=%h, expected no done", hi, lo);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("mon_hi", hi, e.hi);
        chk("mon_lo", lo, e.lo);
        chk("mon_div_zero", {31'b0, div_zero}, {31'b0, e.dz});
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = 3'b110;
  endtask

  task automatic expect_res(input logic [31:0] h, input logic [31:0] l, input logic dz);
    exp_t e;
    e.hi = h; e.lo = l; e.dz = dz;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      n_checks++;
      n_err++;
      $display("FAIL wait_idle_timeout: busy still 1 after %0d cycles, expected 0", n);
    end
  endtask

  task automatic run(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] h, input logic [31:0] l, input logic dz);
    expect_res(h, l, dz);
    issue(o, x, y);
    wait_idle();
    @(negedge clk);
  endtask

  initial begin
    int nb;
    repeat (2) @(negedge clk);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    chk("rst_div_zero", {31'b0, div_zero}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // MULTU max*max with busy width and done pulse width
    expect_res(32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    nb = 0;
    while (busy && nb < 100) begin
      nb++;
      @(negedge clk);
    end
    chk("busy_cycles", 32'(nb), 32'd33);
    chk("done_high", {31'b0, done}, 32'h1);
    @(negedge clk);
    chk("done_one_cycle", {31'b0, done}, 32'h0);

    run(3'b000, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    run(3'b010, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run(3'b010, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
    run(3'b011, 32'd7,         32'd0,        32'h0000_0007, 32'hFFFF_FFFF, 1'b1);
    run(3'b010, 32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);
    run(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);

    // MTHI then MTLO back to back
    @(negedge clk);
    start = 1'b1; op = 3'b100; a = 32'h1234_5678;
    @(negedge clk);
    chk("mthi_hi", hi, 32'h1234_5678);
    chk("mthi_busy", {31'b0, busy}, 32'h0);
    op = 3'b101; a = 32'h9ABC_DEF0;
    @(negedge clk);
    start = 1'b0; op = 3'b110;
    chk("mtlo_lo", lo, 32'h9ABC_DEF0);
    chk("mtlo_hi_kept", hi, 32'h1234_5678);
    chk("mtlo_busy", {31'b0, busy}, 32'h0);

    // start while busy is ignored
    expect_res(32'd2, 32'd14, 1'b0);
    issue(3'b011, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    start = 1'b1; op = 3'b000; a = 32'd3; b = 32'd3;
    @(negedge clk);
    start = 1'b0; op = 3'b110;
    wait_idle();
    repeat (3) @(negedge clk);
    chk("ignored_start_busy", {31'b0, busy}, 32'h0);

    // flush mid-CALC
    issue(3'b000, 32'd3, 32'd4);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", {31'b0, busy}, 32'h0);
    chk("flush_hi", hi, 32'd2);
    chk("flush_lo", lo, 32'd14);
    repeat (40) @(negedge clk);
    chk("flush_hi_late", hi, 32'd2);
    chk("flush_lo_late", lo, 32'd14);

    // flush beats start in IDLE
    start = 1'b1; op = 3'b100; a = 32'hDEAD_BEEF; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; op = 3'b110; flush = 1'b0;
    chk("flush_start_hi", hi, 32'd2);
    chk("flush_start_busy", {31'b0, busy}, 32'h0);

    // async reset mid-CALC
    issue(3'b001, 32'd5, 32'd6);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_hi", hi, 32'h0);
    chk("midrst_lo", lo, 32'h0);
    chk("midrst_busy", {31'b0, busy}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("postrst_busy", {31'b0, busy}, 32'h0);

    chk("pending_expectations", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide unit in the EX stage, beside the ALU.
- Takes the same rs/rt operand buses as the ALU and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Holds the architectural HI/LO registers and drives busy so the hazard unit stalls MFHI/MFLO and new MDU ops.
- Radix-2, one bit per cycle, shared datapath for multiply and divide.

Parameters:
WIDTH, 32, operand/HI/LO width
CNT_W, 6, iteration counter width (must hold WIDTH)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  op valid this cycle (sampled only in IDLE)
op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x NOP
a  in  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO source)
b  in  WIDTH  rt operand (divisor / multiplier)
flush  in  1  abort in-flight op (branch/exception squash)
busy  out  1  op in progress; stall consumers
done  out  1  one-cycle pulse: HI/LO just updated by mul/div
div_zero  out  1  valid with done; divisor was zero
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (async, rst_n=0):
  - hi=0, lo=0, busy=0, done=0, div_zero=0; state IDLE; counter 0.
  - Takes effect mid-operation, and any in-flight op is lost.
- States: IDLE -> CALC -> FIX -> IDLE.
- IDLE, start=1 with op MTHI/MTLO:
  - hi (or lo) <= a at the same edge.
  - busy stays 0; no done.
- IDLE, start=1 with mul/div op:
  - Latch operands: absolute values for signed ops, raw for unsigned.
  - Latch result signs: product sign = a[31]^b[31]; quotient sign = a[31]^b[31]; remainder sign = a[31].
  - Counter=0; go to CALC; busy=1 from this edge.
- CALC, 32 cycles, counter 0..31:
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring divide, 1 quotient bit per cycle, remainder in the upper half.
  - When counter=31, go to FIX.
- FIX, 1 cycle:
  - Apply two's-complement sign fixes.
  - Write hi/lo:
    - mul: hi=product[63:32], lo=product[31:0].
    - div: lo=quotient, hi=remainder.
  - Return to IDLE at this edge; busy=0; done=1 for the following cycle only.
- Latency: start at edge k -> hi/lo valid and done high after edge k+33; busy high across edges k..k+32.
- Divide by zero: no trap. Natural restoring result: lo=0xFFFFFFFF, hi=dividend (signed: original a). div_zero=1 with done.
- Signed overflow 0x80000000 / -1: lo=0x80000000, hi=0, div_zero=0.
- start while busy: ignored. Operand and op changes during CALC have no effect.
- flush:
  - In CALC/FIX: return to IDLE next edge; hi/lo unchanged; no done.
  - flush and start in the same IDLE cycle: flush wins, op dropped.
- hi/lo change only at the FIX edge, on MTHI/MTLO, or on reset.
- Counter wraps only via the state transition, never free-runs.

Decomposition:
- Shared package mdu_pkg:
  - op encodings MDU_MULT..MDU_MTLO and state encodings.
  - WIDTH default and the constants DIV0_QUOT (0xFFFFFFFF) and ITER (32).
- Optional sub-module mdu_sign_fix: combinational abs-in/negate-out helper. Everything else stays in one module.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> after 33 edges hi=0xFFFFFFFE, lo=0x00000001, done pulse exactly 1 cycle, busy high exactly 33 cycles.
- MULT a=0xFFFFFFFD(-3) b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; then DIV a=0xFFFFFFF9(-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=7 b=0 -> lo=0xFFFFFFFF, hi=7, div_zero=1 with done. DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.
- MTHI a=0x12345678 then MTLO a=0x9ABCDEF0 in consecutive cycles -> hi/lo update next edge each, busy never asserts.
- DIVU 100/7 started, second start with MULT at cycle 5 -> ignored, final lo=14, hi=2.
- MULT started, flush at CALC cycle 10 -> busy=0 next cycle, hi/lo unchanged, no done. Separately, rst_n=0 mid-CALC -> hi=lo=0, busy=0 immediately.
